dcache_controller: RTL

Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the external data memory. It produces `dcache_stall`, which freezes the pipeline registers, and `mem_read_data`, which the MEM/WB register captures. On a read miss it refills one 4-word line from memory. Every store is written through to memory before the pipeline is released.

---
 rtl/dcache_controller.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Read misses refill a whole line; every store is written through before release.
module dcache_controller #(
  parameter int ADDR_W    = 12,
  parameter int NUM_LINES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_byte_en,
  output logic              dcache_stall,
  output logic [31:0]       mem_read_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [1:0]         rcnt_r;
  logic [NUM_LINES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r  [NUM_LINES];
  logic [31:0]        data_r [NUM_LINES*4];

  logic [IDX_W-1:0]   idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic [1:0]         word_s;
  logic               hit_s;
  logic [ADDR_W-1:0]  refill_addr_s;
  logic               unused_s;

  assign idx_s         = cpu_addr[3+IDX_W:4];
  assign tag_s         = cpu_addr[ADDR_W-1:4+IDX_W];
  assign word_s        = cpu_addr[3:2];
  assign hit_s         = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign refill_addr_s = {tag_s, idx_s, rcnt_r, 2'b00};
  // Byte offset plays no part in lookup or memory addressing.
  assign unused_s      = ^cpu_addr[1:0];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode, stall and memory-side request outputs.
  always_comb begin
    next_state_s = state_r;
    dcache_stall = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = {ADDR_W{1'b0}};
    mem_wdata    = 32'd0;
    mem_be       = 4'd0;
    case (state_r)
      IDLE: begin
        if (cpu_read) begin
          mem_addr = refill_addr_s;
        end else begin
          mem_addr = {ADDR_W{1'b0}};
        end
        if (cpu_write) begin
          next_state_s = WRITE;
          dcache_stall = 1'b1;
        end else if (cpu_read && !hit_s) begin
          next_state_s = REFILL;
          dcache_stall = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      REFILL: begin
        dcache_stall = 1'b1;
        mem_req      = 1'b1;
        mem_addr     = refill_addr_s;
        if (mem_ready && (rcnt_r == 2'd3)) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = REFILL;
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cpu_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = cpu_wdata;
        mem_be    = cpu_byte_en;
        if (mem_ready) begin
          next_state_s = IDLE;
          dcache_stall = 1'b0;
        end else begin
          next_state_s = WRITE;
          dcache_stall = 1'b1;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Load data path; the array is read combinationally for zero-latency hits.
  always_comb begin
    if (cpu_read) begin
      mem_read_data = data_r[{idx_s, word_s}];
    end else begin
      mem_read_data = 32'd0;
    end
  end

  // Refill word counter and line valid bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt_r  <= 2'd0;
      valid_r <= {NUM_LINES{1'b0}};
    end else if ((state_r == IDLE) && (next_state_s == REFILL)) begin
      rcnt_r <= 2'd0;
    end else if ((state_r == REFILL) && mem_ready) begin
      rcnt_r <= rcnt_r + 2'd1;
      if (rcnt_r == 2'd3) begin
        valid_r[idx_s] <= 1'b1;
      end
    end
  end

  // Tag and data arrays; unreset, writes only happen from REFILL or WRITE.
  always_ff @(posedge clk) begin
    if ((state_r == REFILL) && mem_ready) begin
      data_r[{idx_s, rcnt_r}] <= mem_rdata;
      if (rcnt_r == 2'd3) begin
        tag_r[idx_s] <= tag_s;
      end
    end else if ((state_r == WRITE) && mem_ready && hit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_byte_en[b]) begin
          data_r[{idx_s, word_s}][8*b +: 8] <= cpu_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
